udt_udp_tx_mux: RTL and testbench
=================================

Name: udt_udp_tx_mux

Overview:
- Parametrised N-channel packet multiplexer in front of the UDP transmit interface, all in the udp_clk domain.
- Arbitrates whole packets from NUM_CH AXI-stream sources using round-robin, and attaches per-channel destination IP and port, latched at grant time.
- Enforces a maximum datagram length: over-length packets are truncated and the input tail is dropped.
- Replaces the single fixed-destination UDT→UDP path so several UDT connections can share one UDP stack.

Parameters:
- NUM_CH, 4, number of input channels (1..16).
- DATA_WIDTH, 64, stream data width in bits (multiple of 8).
- KEEP_WIDTH, DATA_WIDTH/8, byte-enable width.
- MAX_BEATS, 182, maximum beats per output datagram (182×8 = 1456 B).
- FPGA_MAC_SRC, 48'hba0203040506, source MAC.
- FPGA_MAC_DES, 48'hffffffffffff, destination MAC.
- FPGA_IP_SRC, 32'hc0a8006f, source IP.
- PORT, 10086, source UDP port.

Ports:
- udp_clk  in  1  sole clock.
- udp_aresetn  in  1  reset, synchronous, active-low.
- s_axis_tvalid  in  NUM_CH  per-channel valid.
- s_axis_tready  out  NUM_CH  per-channel ready.
- s_axis_tdata  in  NUM_CH*DATA_WIDTH  channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tkeep  in  NUM_CH*KEEP_WIDTH  per-channel byte enables.
- s_axis_tlast  in  NUM_CH  per-channel end of packet.
- ch_enable  in  NUM_CH  channel may be granted.
- ch_ip_dest  in  NUM_CH*32  per-channel destination IP.
- ch_port_dest  in  NUM_CH*16  per-channel destination port.
- udp_tx_tready  in  1  UDP stack ready.
- udp_tx_tvalid / udp_tx_tlast  out  1  output valid / end of datagram.
- udp_tx_tkeep  out  KEEP_WIDTH  output byte enables.
- udp_tx_tdata  out  DATA_WIDTH  output data.
- udp_tx_mac_src / udp_tx_mac_dest  out  48  from parameters.
- udp_tx_ip_src / udp_tx_ip_dest  out  32  source IP; latched destination IP.
- udp_tx_port_src / udp_tx_port_dest  out  16  PORT[15:0]; latched destination port.
- grant_ch  out  clog2(NUM_CH) (min 1)  channel currently or last granted.
- oversize_err  out  NUM_CH  sticky truncation flag per channel.
- pkt_count  out  NUM_CH*32  datagrams completed per channel.

Behaviour:
- Clock and reset: one clock, udp_clk; reset udp_aresetn is synchronous, active-low.
- Reset values: all s_axis_tready=0, udp_tx_tvalid=0, udp_tx_tlast=0, udp_tx_ip_dest=0, udp_tx_port_dest=0, grant_ch=0, oversize_err=0, pkt_count=0. Round-robin pointer resets so that channel 0 has first priority.
- Reset mid-packet: aborts immediately, with no tlast emitted; downstream is reset in the same domain.
- MAC/IP/port source outputs: constant from parameters.
- State IDLE: request vector req = s_axis_tvalid & ch_enable.
  - If req≠0, choose the first requester at or after (last_grant+1) mod NUM_CH.
  - Register grant_ch, udp_tx_ip_dest and udp_tx_port_dest from that channel; clear beat_cnt; go to STREAM.
  - All tready=0 in IDLE, so arbitration costs one cycle.
- State STREAM, combinational pass-through from granted channel g:
  - udp_tx_tvalid = s_axis_tvalid[g]; s_axis_tready[g] = udp_tx_tready; data and keep forwarded unchanged.
  - All other channels have tready=0.
  - udp_tx_tlast = s_axis_tlast[g] | (beat_cnt==MAX_BEATS-1).
  - beat_cnt increments on each accepted beat.
  - Accepted beat with input tlast: pkt_count[g]++ (32-bit, wraps), last_grant=g, go to IDLE.
  - Accepted beat with beat_cnt==MAX_BEATS-1 and no input tlast: pkt_count[g]++, oversize_err[g]=1, go to DROP.
  - A packet of exactly MAX_BEATS with tlast on the last beat is legal and sets no error.
- State DROP: s_axis_tready[g]=1, udp_tx_tvalid=0. Input beats are discarded until an accepted tlast, then last_grant=g and go to IDLE.
- Destination hold: destination IP/port stay stable from grant until the next grant; changes on ch_ip_dest/ch_port_dest mid-packet are ignored.
- ch_enable deassertion mid-packet: has no effect until the packet completes.
- Simultaneous requests: strict rotation, with no starvation.
- Single requester: it is regranted after the one-cycle IDLE bubble.
- oversize_err: clears only on reset.

Decomposition:
- Shared package udt_pkg holds FPGA_MAC_SRC, FPGA_MAC_DES, FPGA_IP_SRC, PORT, the state encoding (IDLE/STREAM/DROP) and the clog2 helper.
- Natural sub-module: udt_rr_arbiter (parametrised NUM_CH). Inputs: req, last_grant. Outputs: grant index and grant_valid. Purely combinational.
- FSM, latches and counters live in udt_udp_tx_mux.

Test Plan:
- Single channel 0, 4-beat packet with tlast on beat 4, ch_ip_dest[0]=c0a80010, port 5000, tready=1 → 4 output beats, tlast on beat 4, ip_dest=c0a80010, port_dest=5000, pkt_count[0]=1.
- Channels 0..3 all valid with back-to-back 2-beat packets → grant order 0,1,2,3,0, one idle cycle between packets, each pkt_count=1 after the first round.
- Channel 1 sends a 200-beat packet with MAX_BEATS=182 → output tlast on beat 182, oversize_err[1]=1, 18 input beats accepted with udp_tx_tvalid=0, then IDLE.
- Random udp_tx_tready toggling (50%) on a 10-beat packet → output data sequence is identical to input, with no duplication or loss, and tready mirrors downstream ready.
- Change ch_ip_dest[2] and drop ch_enable[2] mid-packet → udp_tx_ip_dest is unchanged and the packet completes; channel 2 is not granted afterwards.
- Assert udp_aresetn=0 for one cycle during beat 3 of a packet → next cycle all outputs at reset values, counters 0, and channel 0 has first priority.

Source files
------------

// File: rtl/udt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : udt_pkg
// Brief    : Shared constants, FSM state encoding and width helper for the
//            UDT-to-UDP transmit multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
package udt_pkg;

    localparam logic [47:0] FPGA_MAC_SRC = 48'hba0203040506;
    localparam logic [47:0] FPGA_MAC_DES = 48'hffffffffffff;
    localparam logic [31:0] FPGA_IP_SRC  = 32'hc0a8006f;
    localparam int          PORT         = 10086;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DROP   = 2'd2
    } state_t;

    // Bits needed to index `value` items, never less than one.
    function automatic int clog2_min1(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/udt_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : udt_rr_arbiter
// Brief    : Combinational round-robin picker: first requester at or after
//            (last_grant + 1) mod NUM_CH.
// Revision : 1.0 - initial release
// ============================================================================
module udt_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last_grant,
    output logic [IDX_W-1:0]  grant,
    output logic              grant_valid
);

    int w_idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        w_idx       = 0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_idx = (int'(last_grant) + k) % NUM_CH;
            if (req[IDX_W'(w_idx)]) begin
                grant       = IDX_W'(w_idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/udt_udp_tx_mux.sv
`default_nettype none
// ============================================================================
// Module   : udt_udp_tx_mux
// Brief    : Packet-level round-robin mux of NUM_CH AXI-stream sources onto the
//            UDP transmit port, with per-channel destination and length cap.
// Revision : 1.0 - initial release
// ============================================================================
module udt_udp_tx_mux #(
    parameter int          NUM_CH       = 4,
    parameter int          DATA_WIDTH   = 64,
    parameter int          KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int          MAX_BEATS    = 182,
    parameter logic [47:0] FPGA_MAC_SRC = udt_pkg::FPGA_MAC_SRC,
    parameter logic [47:0] FPGA_MAC_DES = udt_pkg::FPGA_MAC_DES,
    parameter logic [31:0] FPGA_IP_SRC  = udt_pkg::FPGA_IP_SRC,
    parameter int          PORT         = udt_pkg::PORT
) (
    input  logic                                      udp_clk,
    input  logic                                      udp_aresetn,
    input  logic [NUM_CH-1:0]                         s_axis_tvalid,
    output logic [NUM_CH-1:0]                         s_axis_tready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]              s_axis_tdata,
    input  logic [NUM_CH*KEEP_WIDTH-1:0]              s_axis_tkeep,
    input  logic [NUM_CH-1:0]                         s_axis_tlast,
    input  logic [NUM_CH-1:0]                         ch_enable,
    input  logic [NUM_CH*32-1:0]                      ch_ip_dest,
    input  logic [NUM_CH*16-1:0]                      ch_port_dest,
    input  logic                                      udp_tx_tready,
    output logic                                      udp_tx_tvalid,
    output logic                                      udp_tx_tlast,
    output logic [KEEP_WIDTH-1:0]                     udp_tx_tkeep,
    output logic [DATA_WIDTH-1:0]                     udp_tx_tdata,
    output logic [47:0]                               udp_tx_mac_src,
    output logic [47:0]                               udp_tx_mac_dest,
    output logic [31:0]                               udp_tx_ip_src,
    output logic [31:0]                               udp_tx_ip_dest,
    output logic [15:0]                               udp_tx_port_src,
    output logic [15:0]                               udp_tx_port_dest,
    output logic [udt_pkg::clog2_min1(NUM_CH)-1:0]    grant_ch,
    output logic [NUM_CH-1:0]                         oversize_err,
    output logic [NUM_CH*32-1:0]                      pkt_count
);

    import udt_pkg::*;

    localparam int                  c_IDX_W     = clog2_min1(NUM_CH);
    localparam int                  c_BEAT_W    = clog2_min1(MAX_BEATS + 1);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(MAX_BEATS - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_IDX_W-1:0]     r_grant;
    logic [c_IDX_W-1:0]     r_last_grant;
    logic [c_IDX_W-1:0]     w_arb_grant;
    logic                   w_arb_valid;
    logic [c_BEAT_W-1:0]    r_beat_cnt;
    logic [31:0]            r_ip_dest;
    logic [15:0]            r_port_dest;
    logic [NUM_CH-1:0]      r_oversize;
    logic [31:0]            r_pkt_count [NUM_CH];

    logic [DATA_WIDTH-1:0]  w_data [NUM_CH];
    logic [KEEP_WIDTH-1:0]  w_keep [NUM_CH];
    logic [31:0]            w_ip   [NUM_CH];
    logic [15:0]            w_port [NUM_CH];
    logic [NUM_CH-1:0]      w_req;
    logic                   w_src_valid;
    logic                   w_src_last;
    logic                   w_at_limit;
    logic                   w_accept;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign w_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            assign w_keep[i] = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
            assign w_ip[i]   = ch_ip_dest[i*32 +: 32];
            assign w_port[i] = ch_port_dest[i*16 +: 16];
            assign pkt_count[i*32 +: 32] = r_pkt_count[i];
        end
    endgenerate

    assign w_req       = s_axis_tvalid & ch_enable;
    assign w_src_valid = s_axis_tvalid[r_grant];
    assign w_src_last  = s_axis_tlast[r_grant];
    assign w_at_limit  = (r_beat_cnt == c_LAST_BEAT);

    assign udp_tx_tdata     = w_data[r_grant];
    assign udp_tx_tkeep     = w_keep[r_grant];
    assign udp_tx_mac_src   = FPGA_MAC_SRC;
    assign udp_tx_mac_dest  = FPGA_MAC_DES;
    assign udp_tx_ip_src    = FPGA_IP_SRC;
    assign udp_tx_port_src  = PORT[15:0];
    assign udp_tx_ip_dest   = r_ip_dest;
    assign udp_tx_port_dest = r_port_dest;
    assign grant_ch         = r_grant;
    assign oversize_err     = r_oversize;

    udt_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (c_IDX_W)
    ) u_arb (
        .req         (w_req),
        .last_grant  (r_last_grant),
        .grant       (w_arb_grant),
        .grant_valid (w_arb_valid)
    );

    always_ff @(posedge udp_clk) begin
        if (!udp_aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        s_axis_tready = '0;
        udp_tx_tvalid = 1'b0;
        udp_tx_tlast  = 1'b0;
        w_accept      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                s_axis_tready[r_grant] = udp_tx_tready;
                udp_tx_tvalid          = w_src_valid;
                udp_tx_tlast           = w_src_last | w_at_limit;
                w_accept               = w_src_valid & udp_tx_tready;
                if (w_accept) begin
                    if (w_src_last) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_at_limit) begin
                        w_state_nxt = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                // Swallow the over-length tail without presenting it downstream.
                s_axis_tready[r_grant] = 1'b1;
                w_accept               = w_src_valid;
                if (w_src_valid & w_src_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge udp_clk) begin
        if (!udp_aresetn) begin
            r_grant      <= '0;
            // Pointer parked on the last channel so channel 0 wins first.
            r_last_grant <= c_IDX_W'(NUM_CH - 1);
            r_beat_cnt   <= '0;
            r_ip_dest    <= '0;
            r_port_dest  <= '0;
            r_oversize   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_pkt_count[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_grant     <= w_arb_grant;
                        r_ip_dest   <= w_ip[w_arb_grant];
                        r_port_dest <= w_port[w_arb_grant];
                        r_beat_cnt  <= '0;
                    end
                end
                ST_STREAM: begin
                    if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + c_BEAT_W'(1);
                        if (w_src_last) begin
                            r_pkt_count[r_grant] <= r_pkt_count[r_grant] + 32'd1;
                            r_last_grant         <= r_grant;
                        end else if (w_at_limit) begin
                            r_pkt_count[r_grant] <= r_pkt_count[r_grant] + 32'd1;
                            r_oversize[r_grant]  <= 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    if (w_accept & w_src_last) begin
                        r_last_grant <= r_grant;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_udt_udp_tx_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_udt_udp_tx_mux
// Brief    : Randomized bench for udt_udp_tx_mux against a packet-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_udt_udp_tx_mux;

    localparam int NUM_CH = 4;
    localparam int DW     = 64;
    localparam int KW     = 8;
    localparam int MAXB   = 182;

    logic                  clk = 1'b0;
    logic                  udp_aresetn;
    logic [NUM_CH-1:0]     s_axis_tvalid;
    logic [NUM_CH-1:0]     s_axis_tready;
    logic [NUM_CH*DW-1:0]  s_axis_tdata;
    logic [NUM_CH*KW-1:0]  s_axis_tkeep;
    logic [NUM_CH-1:0]     s_axis_tlast;
    logic [NUM_CH-1:0]     ch_enable;
    logic [NUM_CH*32-1:0]  ch_ip_dest;
    logic [NUM_CH*16-1:0]  ch_port_dest;
    logic                  udp_tx_tready;
    logic                  udp_tx_tvalid;
    logic                  udp_tx_tlast;
    logic [KW-1:0]         udp_tx_tkeep;
    logic [DW-1:0]         udp_tx_tdata;
    logic [47:0]           udp_tx_mac_src;
    logic [47:0]           udp_tx_mac_dest;
    logic [31:0]           udp_tx_ip_src;
    logic [31:0]           udp_tx_ip_dest;
    logic [15:0]           udp_tx_port_src;
    logic [15:0]           udp_tx_port_dest;
    logic [1:0]            grant_ch;
    logic [NUM_CH-1:0]     oversize_err;
    logic [NUM_CH*32-1:0]  pkt_count;

    always #5 clk = ~clk;

    udt_udp_tx_mux #(
        .NUM_CH     (NUM_CH),
        .DATA_WIDTH (DW),
        .MAX_BEATS  (MAXB)
    ) dut (
        .udp_clk          (clk),
        .udp_aresetn      (udp_aresetn),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tkeep     (s_axis_tkeep),
        .s_axis_tlast     (s_axis_tlast),
        .ch_enable        (ch_enable),
        .ch_ip_dest       (ch_ip_dest),
        .ch_port_dest     (ch_port_dest),
        .udp_tx_tready    (udp_tx_tready),
        .udp_tx_tvalid    (udp_tx_tvalid),
        .udp_tx_tlast     (udp_tx_tlast),
        .udp_tx_tkeep     (udp_tx_tkeep),
        .udp_tx_tdata     (udp_tx_tdata),
        .udp_tx_mac_src   (udp_tx_mac_src),
        .udp_tx_mac_dest  (udp_tx_mac_dest),
        .udp_tx_ip_src    (udp_tx_ip_src),
        .udp_tx_ip_dest   (udp_tx_ip_dest),
        .udp_tx_port_src  (udp_tx_port_src),
        .udp_tx_port_dest (udp_tx_port_dest),
        .grant_ch         (grant_ch),
        .oversize_err     (oversize_err),
        .pkt_count        (pkt_count)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    beat_t             src_q [NUM_CH][$];
    logic [NUM_CH-1:0] src_vld;
    int                gen_left;
    int                n_checks = 0;
    int                n_errors = 0;

    // Packet-level reference state
    bit                m_busy;
    bit                m_drop;
    int                m_ch;
    int                m_last;
    int                m_obeats;
    logic [31:0]       m_ip;
    logic [15:0]       m_port;
    logic [31:0]       m_pkt [NUM_CH];
    logic [NUM_CH-1:0] m_ovf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_busy   = 1'b0;
        m_drop   = 1'b0;
        m_ch     = 0;
        m_last   = NUM_CH - 1;
        m_obeats = 0;
        m_ovf    = '0;
        for (int i = 0; i < NUM_CH; i++) m_pkt[i] = '0;
    endtask

    task automatic gen_packet(input int ch);
        int len;
        beat_t bt;
        if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
                0:       len = MAXB - 1;
                1:       len = MAXB;
                2:       len = MAXB + 1;
                default: len = 200;
            endcase
        end else begin
            len = $urandom_range(1, 12);
        end
        for (int b = 0; b < len; b++) begin
            bt.data = {$urandom, $urandom};
            bt.keep = (b == len - 1) ? 8'($urandom_range(1, 255)) : 8'hff;
            bt.last = (b == len - 1);
            src_q[ch].push_back(bt);
        end
    endtask

    function automatic int pending();
        int p;
        p = m_busy ? 1 : 0;
        for (int i = 0; i < NUM_CH; i++) p += src_q[i].size();
        return p;
    endfunction

    task automatic drive();
        beat_t cur;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!src_vld[i]) begin
                if (src_q[i].size() == 0 && gen_left > 0 && $urandom_range(0, 3) == 0) begin
                    gen_packet(i);
                    gen_left--;
                end
                if (src_q[i].size() != 0 && $urandom_range(0, 3) != 0) src_vld[i] = 1'b1;
            end
            cur = (src_q[i].size() != 0) ? src_q[i][0] : '0;
            s_axis_tvalid[i]           = src_vld[i];
            s_axis_tdata[i*DW +: DW]   = cur.data;
            s_axis_tkeep[i*KW +: KW]   = cur.keep;
            s_axis_tlast[i]            = cur.last;
            if ($urandom_range(0, 31) == 0) ch_enable[i] = ~ch_enable[i];
            if ($urandom_range(0, 15) == 0) begin
                ch_ip_dest[i*32 +: 32]   = $urandom;
                ch_port_dest[i*16 +: 16] = 16'($urandom);
            end
        end
        udp_tx_tready = ($urandom_range(0, 1) == 1);
    endtask

    // Compare the settled outputs of this cycle, then advance model and sources
    // as the coming clock edge will.
    task automatic eval_cycle();
        logic [NUM_CH-1:0] req;
        logic [NUM_CH-1:0] exp_rdy;
        int    g;
        beat_t cur;
        if (!m_busy) begin
            check("idle_tready", 64'(s_axis_tready), 64'd0);
            check("idle_tvalid", 64'(udp_tx_tvalid), 64'd0);
            for (int i = 0; i < NUM_CH; i++) begin
                check($sformatf("pkt_count[%0d]", i), 64'(pkt_count[i*32 +: 32]), 64'(m_pkt[i]));
            end
            check("oversize_err", 64'(oversize_err), 64'(m_ovf));
            req = s_axis_tvalid & ch_enable;
            g = -1;
            for (int k = 1; k <= NUM_CH; k++) begin
                if (g < 0 && req[(m_last + k) % NUM_CH]) g = (m_last + k) % NUM_CH;
            end
            if (g >= 0) begin
                m_busy   = 1'b1;
                m_drop   = 1'b0;
                m_ch     = g;
                m_obeats = 0;
                m_ip     = ch_ip_dest[g*32 +: 32];
                m_port   = ch_port_dest[g*16 +: 16];
            end
        end else begin
            cur = (src_q[m_ch].size() != 0) ? src_q[m_ch][0] : '0;
            check("grant_ch", 64'(grant_ch), 64'(m_ch));
            check("ip_dest", 64'(udp_tx_ip_dest), 64'(m_ip));
            check("port_dest", 64'(udp_tx_port_dest), 64'(m_port));
            exp_rdy = '0;
            if (m_drop) begin
                exp_rdy[m_ch] = 1'b1;
                check("drop_tready", 64'(s_axis_tready), 64'(exp_rdy));
                check("drop_tvalid", 64'(udp_tx_tvalid), 64'd0);
                if (src_vld[m_ch]) begin
                    void'(src_q[m_ch].pop_front());
                    src_vld[m_ch] = 1'b0;
                    if (cur.last) begin
                        m_busy = 1'b0;
                        m_last = m_ch;
                    end
                end
            end else begin
                exp_rdy[m_ch] = udp_tx_tready;
                check("tready", 64'(s_axis_tready), 64'(exp_rdy));
                check("tvalid", 64'(udp_tx_tvalid), 64'(src_vld[m_ch]));
                if (src_vld[m_ch]) begin
                    check("tdata", udp_tx_tdata, cur.data);
                    check("tkeep", 64'(udp_tx_tkeep), 64'(cur.keep));
                    check("tlast", 64'(udp_tx_tlast), 64'(cur.last || (m_obeats == MAXB - 1)));
                end
                if (src_vld[m_ch] && udp_tx_tready) begin
                    void'(src_q[m_ch].pop_front());
                    src_vld[m_ch] = 1'b0;
                    if (cur.last) begin
                        m_pkt[m_ch]++;
                        m_busy = 1'b0;
                        m_last = m_ch;
                    end else if (m_obeats == MAXB - 1) begin
                        m_pkt[m_ch]++;
                        m_ovf[m_ch] = 1'b1;
                        m_drop      = 1'b1;
                    end
                    m_obeats++;
                end
            end
        end
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            drive();
            #1;
            eval_cycle();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"}, 64'(udp_tx_tvalid), 64'd0);
        check({tag, "_tlast"}, 64'(udp_tx_tlast), 64'd0);
        check({tag, "_tready"}, 64'(s_axis_tready), 64'd0);
        check({tag, "_ip_dest"}, 64'(udp_tx_ip_dest), 64'd0);
        check({tag, "_port_dest"}, 64'(udp_tx_port_dest), 64'd0);
        check({tag, "_grant"}, 64'(grant_ch), 64'd0);
        check({tag, "_oversize"}, 64'(oversize_err), 64'd0);
        for (int i = 0; i < NUM_CH; i++) begin
            check($sformatf("%s_pkt[%0d]", tag, i), 64'(pkt_count[i*32 +: 32]), 64'd0);
        end
    endtask

    task automatic clear_sources();
        for (int i = 0; i < NUM_CH; i++) src_q[i].delete();
        src_vld       = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
    endtask

    initial begin
        int waited;
        udp_aresetn   = 1'b0;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = '0;
        ch_enable     = '1;
        udp_tx_tready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_ip_dest[i*32 +: 32]   = $urandom;
            ch_port_dest[i*16 +: 16] = 16'($urandom);
        end
        src_vld  = '0;
        gen_left = 60;
        model_reset();

        repeat (3) @(negedge clk);
        udp_aresetn = 1'b1;
        #1;
        check_reset_outputs("por");
        check("mac_src", 64'(udp_tx_mac_src), 64'h0000ba0203040506);
        check("mac_dest", 64'(udp_tx_mac_dest), 64'h0000ffffffffffff);
        check("ip_src", 64'(udp_tx_ip_src), 64'h00000000c0a8006f);
        check("port_src", 64'(udp_tx_port_src), 64'd10086);

        run_cycles(8000);

        // Reset while the third beat of a packet is on the bus.
        gen_left = 20;
        waited   = 0;
        while (!(m_busy && !m_drop && m_obeats == 2) && waited < 5000) begin
            run_cycles(1);
            waited++;
        end
        check("reach_beat3", 64'(m_busy && !m_drop && m_obeats == 2), 64'd1);
        @(negedge clk);
        drive();
        udp_aresetn = 1'b0;
        @(negedge clk);
        udp_aresetn = 1'b1;
        #1;
        check_reset_outputs("midrst");
        clear_sources();
        model_reset();

        // All channels contend immediately after reset: channel 0 must win.
        ch_enable = '1;
        for (int i = 0; i < NUM_CH; i++) gen_packet(i);
        src_vld  = '1;
        gen_left = 40;
        run_cycles(4000);

        gen_left = 0;
        waited   = 0;
        while (pending() != 0 && waited < 20000) begin
            run_cycles(1);
            waited++;
        end
        check("drain_done", 64'(pending()), 64'd0);
        run_cycles(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
